otter_ctrl_unit: RTL and testbench
==================================

Name: otter_ctrl_unit

Overview:
- Multi-cycle control unit for the RV32I Otter core. It sequences INIT/FETCH/EXEC/WB and decodes the instruction register.
- It is the producer side of the ALU interface: it drives the 4-bit ALU function code, the ALU operand-source selects, register-file and memory enables, and the PC source.
- It sits between instruction memory (IR) plus the branch comparator, and the datapath muxes.

Parameters:
- RESET_INIT_CYCLES, 1, number of cycles held in ST_INIT after reset deasserts (1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IR  in  32  current instruction from memory port 1; valid from ST_EXEC onward.
- BR_EQ  in  1  rs1 == rs2.
- BR_LT  in  1  signed rs1 < rs2.
- BR_LTU  in  1  unsigned rs1 < rs2.
- PC_WE  out  1  PC write enable.
- RF_WE  out  1  register-file write enable.
- MEM_RDEN1  out  1  instruction fetch read enable.
- MEM_RDEN2  out  1  data read enable.
- MEM_WE2  out  1  data write enable.
- ALU_FUN  out  4  ALU function code.
- ALU_SRCA  out  1  0 = rs1, 1 = U-immediate.
- ALU_SRCB  out  2  0 = rs2, 1 = I-imm, 2 = S-imm, 3 = PC.
- PC_SOURCE  out  3  0 = PC+4, 1 = JALR, 2 = branch, 3 = JAL, 4 = mtvec, 5 = mepc.
- RF_WR_SEL  out  2  0 = PC+4, 1 = CSR, 2 = memory, 3 = ALU result.

Behaviour:
- Reset: RST is sampled on the CLK rising edge. It is synchronous and active-high.
  - While RST is high and in the following cycle: state = ST_INIT, all enables 0, ALU_FUN = 0000, all selects 0.
  - RST asserted in any state, including mid-load in ST_WB, aborts the instruction. No RF or memory write occurs in the reset cycle.
- ST_INIT: hold RESET_INIT_CYCLES cycles (4-bit counter), then go to ST_FETCH.
- ST_FETCH: MEM_RDEN1 = 1, nothing else asserted. Next state is ST_EXEC.
- ST_EXEC: all outputs are decoded combinationally from IR.
  - Default action: PC_WE = 1 and next state ST_FETCH.
  - Loads instead drive MEM_RDEN2 = 1 and PC_WE = 0, with next state ST_WB.
- ST_WB (loads only): RF_WE = 1, RF_WR_SEL = 2, PC_WE = 1, PC_SOURCE = 0. Next state is ST_FETCH.
- CPI: 2 cycles per instruction; loads take 3.
- ALU_FUN decode:
  - OP (0110011): {IR[30], funct3}.
  - OP-IMM (0010011): {IR[30] if funct3 == 101, else 0, funct3}.
  - LUI: 1001.
  - All other opcodes: 0000.
- Per-opcode EXEC outputs:
  - OP: RF_WE = 1, SRCB = 0, WR_SEL = 3.
  - OP-IMM: RF_WE = 1, SRCB = 1, WR_SEL = 3.
  - LUI: SRCA = 1, RF_WE = 1, WR_SEL = 3.
  - AUIPC: SRCA = 1, SRCB = 3, RF_WE = 1, WR_SEL = 3.
  - JAL: PC_SOURCE = 3, RF_WE = 1, WR_SEL = 0.
  - JALR: PC_SOURCE = 1, RF_WE = 1, WR_SEL = 0.
  - LOAD: SRCB = 1, MEM_RDEN2 = 1.
  - STORE: SRCB = 2, MEM_WE2 = 1.
  - BRANCH: PC_SOURCE = 2 if taken, else 0.
- Branch taken conditions by funct3:
  - 000: BR_EQ.
  - 001: !BR_EQ.
  - 100: BR_LT.
  - 101: !BR_LT.
  - 110: BR_LTU.
  - 111: !BR_LTU.
  - 010 and 011: not taken.
- Illegal opcode: treated as a NOP. PC_WE = 1, PC_SOURCE = 0, no RF or memory writes.
- Writes to x0: not suppressed here; the register file ignores them.
- No enable is ever asserted in ST_INIT or ST_FETCH except MEM_RDEN1.

Optional Feature:
- Macro: OTTER_CTRL_INTR_EN.
- When defined, add these ports:
  - INTR in 1.
  - CSR_MIE in 1.
  - INT_TAKEN out 1.
  - MRET_EXEC out 1.
- When defined, add state ST_INTR:
  - At the end of ST_EXEC (non-load) or ST_WB, if INTR && CSR_MIE, go to ST_INTR instead of ST_FETCH. The current instruction still completes.
  - ST_INTR drives INT_TAKEN = 1, PC_WE = 1, PC_SOURCE = 4, then goes to ST_FETCH.
  - SYSTEM opcode with funct3 = 000 and IR[31:20] = 0x302 (mret): PC_SOURCE = 5, MRET_EXEC = 1.
  - CSRRW: RF_WE = 1, WR_SEL = 1.
- When not defined: the ports and ST_INTR are absent, and SYSTEM is treated as an illegal opcode (NOP).

Decomposition:
- Package otter_ctrl_pkg holds:
  - opcode enum;
  - state enum;
  - ALU_FUN constants (ADD = 0000, SUB = 1000, SLL = 0001, SLT = 0010, SLTU = 0011, XOR = 0100, SRL = 0101, SRA = 1101, OR = 0110, AND = 0111, LUI = 1001);
  - select constants for SRCA, SRCB, PC_SOURCE and RF_WR_SEL.
- One sub-module, otter_ctrl_decoder: purely combinational, IR plus branch flags to EXEC outputs.
- The top level holds the FSM, the INIT counter and the per-state gating.

Test Plan:
- Reset, then IR = 0x002081B3 (add): ST_INIT for 1 cycle; FETCH has MEM_RDEN1 = 1 only; EXEC gives ALU_FUN = 0000, SRCB = 0, RF_WE = 1, WR_SEL = 3, PC_WE = 1.
- IR = 0x402081B3 (sub) -> ALU_FUN = 1000. IR = 0x4030D093 (srai) -> ALU_FUN = 1101, SRCB = 1. IR = 0x4030C093 (xori, IR[30] = 1) -> ALU_FUN = 0100.
- IR = 0x123452B7 (lui) -> ALU_FUN = 1001, SRCA = 1, RF_WE = 1.
- IR = 0x00012083 (lw): EXEC gives MEM_RDEN2 = 1, PC_WE = 0; WB gives RF_WE = 1, WR_SEL = 2, PC_WE = 1; FETCH follows; 3 cycles total.
- IR = 0x00209463 (bne): BR_EQ = 0 -> PC_SOURCE = 2; BR_EQ = 1 -> PC_SOURCE = 0. Both cases PC_WE = 1, RF_WE = 0, MEM_WE2 = 0.
- Assert RST during ST_WB of lw: no RF_WE in that cycle; next cycle in ST_INIT with all outputs 0. With OTTER_CTRL_INTR_EN: INTR = 1 and CSR_MIE = 1 during add EXEC -> ST_INTR with PC_SOURCE = 4, INT_TAKEN = 1.

Source files
------------

// File: rtl/otter_ctrl_pkg.sv
// Shared types and constants for the Otter multi-cycle control unit.
// Optional interrupt support is enabled by defining OTTER_CTRL_INTR_EN.
package otter_ctrl_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_IMM    = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WB    = 3'd3
`ifdef OTTER_CTRL_INTR_EN
      ,
      ST_INTR  = 3'd4
`endif
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_LUI  = 4'b1001;

   localparam logic       SRCA_RS1  = 1'b0;
   localparam logic       SRCA_UIMM = 1'b1;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IIMM = 2'd1;
   localparam logic [1:0] SRCB_SIMM = 2'd2;
   localparam logic [1:0] SRCB_PC   = 2'd3;

   localparam logic [2:0] PCSRC_PLUS4  = 3'd0;
   localparam logic [2:0] PCSRC_JALR   = 3'd1;
   localparam logic [2:0] PCSRC_BRANCH = 3'd2;
   localparam logic [2:0] PCSRC_JAL    = 3'd3;
   localparam logic [2:0] PCSRC_MTVEC  = 3'd4;
   localparam logic [2:0] PCSRC_MEPC   = 3'd5;

   localparam logic [1:0] WRSEL_PC4 = 2'd0;
   localparam logic [1:0] WRSEL_CSR = 2'd1;
   localparam logic [1:0] WRSEL_MEM = 2'd2;
   localparam logic [1:0] WRSEL_ALU = 2'd3;

   // Everything the decoder produces for one instruction in ST_EXEC.
   typedef struct packed {
      logic       pc_we;
      logic       rf_we;
      logic       mem_rden2;
      logic       mem_we2;
      logic [3:0] alu_fun;
      logic       alu_srca;
      logic [1:0] alu_srcb;
      logic [2:0] pc_source;
      logic [1:0] rf_wr_sel;
      logic       is_load;
`ifdef OTTER_CTRL_INTR_EN
      logic       mret_exec;
`endif
   } ctrl_t;

   // Resolve a branch from funct3 and the comparator flags; 010/011 never take.
   function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                         input logic lt, input logic ltu);
      case (funct3)
         3'b000:  return eq;
         3'b001:  return !eq;
         3'b100:  return lt;
         3'b101:  return !lt;
         3'b110:  return ltu;
         3'b111:  return !ltu;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/otter_ctrl_decoder.sv
// Combinational instruction decoder: IR plus branch flags to EXEC-state controls.
// OTTER_CTRL_INTR_EN adds mret and CSRRW decode; otherwise SYSTEM is a NOP.
module otter_ctrl_decoder
   import otter_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   input  logic        br_eq,
   input  logic        br_lt,
   input  logic        br_ltu,
   output ctrl_t       ctrl
);

   opcode_t    opcode;
   logic [2:0] funct3;

   assign opcode = opcode_t'(ir[6:0]);
   assign funct3 = ir[14:12];

`ifdef OTTER_CTRL_INTR_EN
   logic unused_ir;
   assign unused_ir = ^{ir[19:15], ir[11:7]};
`else
   logic unused_ir;
   assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
`endif

   // Per-opcode decode; anything unrecognised falls through as a plain PC+4 NOP.
   always_comb begin
      ctrl           = '0;
      ctrl.pc_we     = 1'b1;
      ctrl.alu_fun   = ALU_ADD;
      ctrl.pc_source = PCSRC_PLUS4;
      case (opcode)
         OPC_OP: begin
            ctrl.alu_fun   = {ir[30], funct3};
            ctrl.alu_srcb  = SRCB_RS2;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WRSEL_ALU;
         end
         OPC_IMM: begin
            ctrl.alu_fun   = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
            ctrl.alu_srcb  = SRCB_IIMM;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WRSEL_ALU;
         end
         OPC_LUI: begin
            ctrl.alu_fun   = ALU_LUI;
            ctrl.alu_srca  = SRCA_UIMM;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WRSEL_ALU;
         end
         OPC_AUIPC: begin
            ctrl.alu_srca  = SRCA_UIMM;
            ctrl.alu_srcb  = SRCB_PC;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WRSEL_ALU;
         end
         OPC_JAL: begin
            ctrl.pc_source = PCSRC_JAL;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WRSEL_PC4;
         end
         OPC_JALR: begin
            ctrl.pc_source = PCSRC_JALR;
            ctrl.rf_we     = 1'b1;
            ctrl.rf_wr_sel = WRSEL_PC4;
         end
         OPC_LOAD: begin
            ctrl.alu_srcb  = SRCB_IIMM;
            ctrl.mem_rden2 = 1'b1;
            ctrl.pc_we     = 1'b0;
            ctrl.is_load   = 1'b1;
         end
         OPC_STORE: begin
            ctrl.alu_srcb  = SRCB_SIMM;
            ctrl.mem_we2   = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl.pc_source = branch_taken(funct3, br_eq, br_lt, br_ltu) ?
                             PCSRC_BRANCH : PCSRC_PLUS4;
         end
`ifdef OTTER_CTRL_INTR_EN
         OPC_SYSTEM: begin
            if (funct3 == 3'b000 && ir[31:20] == 12'h302) begin
               ctrl.pc_source = PCSRC_MEPC;
               ctrl.mret_exec = 1'b1;
            end else if (funct3 == 3'b001) begin
               ctrl.rf_we     = 1'b1;
               ctrl.rf_wr_sel = WRSEL_CSR;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/otter_ctrl_unit.sv
// Otter multi-cycle control unit: INIT/FETCH/EXEC/WB sequencer with state gating.
// Define OTTER_CTRL_INTR_EN to add interrupt entry (ST_INTR) and mret/CSRRW support.
module otter_ctrl_unit
   import otter_ctrl_pkg::*;
#(
   parameter int RESET_INIT_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IR,
   input  logic        BR_EQ,
   input  logic        BR_LT,
   input  logic        BR_LTU,
`ifdef OTTER_CTRL_INTR_EN
   input  logic        INTR,
   input  logic        CSR_MIE,
   output logic        INT_TAKEN,
   output logic        MRET_EXEC,
`endif
   output logic        PC_WE,
   output logic        RF_WE,
   output logic        MEM_RDEN1,
   output logic        MEM_RDEN2,
   output logic        MEM_WE2,
   output logic [3:0]  ALU_FUN,
   output logic        ALU_SRCA,
   output logic [1:0]  ALU_SRCB,
   output logic [2:0]  PC_SOURCE,
   output logic [1:0]  RF_WR_SEL
);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   ctrl_t      dec;
   logic       go_intr;

   otter_ctrl_decoder u_decoder (
      .ir     (IR),
      .br_eq  (BR_EQ),
      .br_lt  (BR_LT),
      .br_ltu (BR_LTU),
      .ctrl   (dec)
   );

`ifdef OTTER_CTRL_INTR_EN
   assign go_intr = INTR && CSR_MIE;
`else
   assign go_intr = 1'b0;
`endif

   // Next-state and INIT hold counter; a pending interrupt diverts the return to FETCH.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            if (cnt_q == 4'(RESET_INIT_CYCLES - 1)) begin
               state_d = ST_FETCH;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            if (dec.is_load) begin
               state_d = ST_WB;
            end else begin
`ifdef OTTER_CTRL_INTR_EN
               state_d = go_intr ? ST_INTR : ST_FETCH;
`else
               state_d = ST_FETCH;
`endif
            end
         end
         ST_WB: begin
`ifdef OTTER_CTRL_INTR_EN
            state_d = go_intr ? ST_INTR : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
         end
`ifdef OTTER_CTRL_INTR_EN
         ST_INTR: state_d = ST_FETCH;
`endif
         default: state_d = ST_INIT;
      endcase
   end

   // State register; reset parks the FSM in INIT with a cleared counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_INIT;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Output gating by state; RST forces everything low so an aborted WB never writes.
   always_comb begin
      PC_WE     = 1'b0;
      RF_WE     = 1'b0;
      MEM_RDEN1 = 1'b0;
      MEM_RDEN2 = 1'b0;
      MEM_WE2   = 1'b0;
      ALU_FUN   = ALU_ADD;
      ALU_SRCA  = SRCA_RS1;
      ALU_SRCB  = SRCB_RS2;
      PC_SOURCE = PCSRC_PLUS4;
      RF_WR_SEL = WRSEL_PC4;
`ifdef OTTER_CTRL_INTR_EN
      INT_TAKEN = 1'b0;
      MRET_EXEC = 1'b0;
`endif
      if (!RST) begin
         case (state_q)
            ST_FETCH: MEM_RDEN1 = 1'b1;
            ST_EXEC: begin
               PC_WE     = dec.pc_we;
               RF_WE     = dec.rf_we;
               MEM_RDEN2 = dec.mem_rden2;
               MEM_WE2   = dec.mem_we2;
               ALU_FUN   = dec.alu_fun;
               ALU_SRCA  = dec.alu_srca;
               ALU_SRCB  = dec.alu_srcb;
               PC_SOURCE = dec.pc_source;
               RF_WR_SEL = dec.rf_wr_sel;
`ifdef OTTER_CTRL_INTR_EN
               MRET_EXEC = dec.mret_exec;
`endif
            end
            ST_WB: begin
               RF_WE     = 1'b1;
               RF_WR_SEL = WRSEL_MEM;
               PC_WE     = 1'b1;
               PC_SOURCE = PCSRC_PLUS4;
            end
`ifdef OTTER_CTRL_INTR_EN
            ST_INTR: begin
               INT_TAKEN = 1'b1;
               PC_WE     = 1'b1;
               PC_SOURCE = PCSRC_MTVEC;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_otter_ctrl_unit.sv
// Self-checking bench for otter_ctrl_unit: directed instructions plus random
// instruction/operand streams compared against an instruction-level model.
module tb_otter_ctrl_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] IR;
   logic        BR_EQ, BR_LT, BR_LTU;
   logic        PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, ALU_SRCA;
   logic [3:0]  ALU_FUN;
   logic [1:0]  ALU_SRCB, RF_WR_SEL;
   logic [2:0]  PC_SOURCE;
`ifdef OTTER_CTRL_INTR_EN
   logic        INTR, CSR_MIE, INT_TAKEN, MRET_EXEC;
`endif

   int testsRun  = 0;
   int failCount = 0;

   typedef struct packed {
      logic       pcWe;
      logic       rfWe;
      logic       rden1;
      logic       rden2;
      logic       we2;
      logic [3:0] fun;
      logic       srcA;
      logic [1:0] srcB;
      logic [2:0] pcSrc;
      logic [1:0] wrSel;
   } outs_t;

   outs_t obs;
   assign obs = {PC_WE, RF_WE, MEM_RDEN1, MEM_RDEN2, MEM_WE2, ALU_FUN,
                 ALU_SRCA, ALU_SRCB, PC_SOURCE, RF_WR_SEL};

   otter_ctrl_unit dut (
      .CLK       (CLK),
      .RST       (RST),
      .IR        (IR),
      .BR_EQ     (BR_EQ),
      .BR_LT     (BR_LT),
      .BR_LTU    (BR_LTU),
`ifdef OTTER_CTRL_INTR_EN
      .INTR      (INTR),
      .CSR_MIE   (CSR_MIE),
      .INT_TAKEN (INT_TAKEN),
      .MRET_EXEC (MRET_EXEC),
`endif
      .PC_WE     (PC_WE),
      .RF_WE     (RF_WE),
      .MEM_RDEN1 (MEM_RDEN1),
      .MEM_RDEN2 (MEM_RDEN2),
      .MEM_WE2   (MEM_WE2),
      .ALU_FUN   (ALU_FUN),
      .ALU_SRCA  (ALU_SRCA),
      .ALU_SRCB  (ALU_SRCB),
      .PC_SOURCE (PC_SOURCE),
      .RF_WR_SEL (RF_WR_SEL)
   );

   // 100 MHz-style free-running clock
   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Branch outcome worked out from the actual register values
   function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // What the EXEC cycle should drive for a given instruction and operands
   function automatic outs_t refExec(input logic [31:0] ir, input logic [31:0] a,
                                     input logic [31:0] b);
      outs_t      e = '0;
      logic [2:0] f3 = ir[14:12];
      e.pcWe = 1'b1;
      case (ir[6:0])
         7'b0110011: begin e.rfWe = 1; e.wrSel = 3; e.fun = {ir[30], f3}; end
         7'b0010011: begin
            e.rfWe = 1; e.wrSel = 3; e.srcB = 1;
            e.fun = (f3 == 3'b101) ? {ir[30], f3} : {1'b0, f3};
         end
         7'b0110111: begin e.rfWe = 1; e.wrSel = 3; e.srcA = 1; e.fun = 4'b1001; end
         7'b0010111: begin e.rfWe = 1; e.wrSel = 3; e.srcA = 1; e.srcB = 3; end
         7'b1101111: begin e.rfWe = 1; e.pcSrc = 3; end
         7'b1100111: begin e.rfWe = 1; e.pcSrc = 1; end
         7'b0000011: begin e.srcB = 1; e.rden2 = 1; e.pcWe = 0; end
         7'b0100011: begin e.srcB = 2; e.we2 = 1; end
         7'b1100011: e.pcSrc = refTaken(f3, a, b) ? 3'd2 : 3'd0;
`ifdef OTTER_CTRL_INTR_EN
         7'b1110011: begin
            if (f3 == 3'b000 && ir[31:20] == 12'h302) e.pcSrc = 3'd5;
            else if (f3 == 3'b001) begin e.rfWe = 1; e.wrSel = 1; end
         end
`endif
         default: ;
      endcase
      return e;
   endfunction

   function automatic outs_t fetchOuts();
      outs_t e = '0;
      e.rden1 = 1'b1;
      return e;
   endfunction

   function automatic outs_t wbOuts();
      outs_t e = '0;
      e.pcWe = 1; e.rfWe = 1; e.wrSel = 2;
      return e;
   endfunction

   task automatic setOperands(input logic [31:0] a, input logic [31:0] b);
      BR_EQ  = (a == b);
      BR_LT  = ($signed(a) < $signed(b));
      BR_LTU = (a < b);
   endtask

   // Runs one instruction from FETCH onwards; entered just after the FETCH-cycle edge
   task automatic applyStimulus(input string tag, input logic [31:0] ir,
                                input logic [31:0] a, input logic [31:0] b);
      IR = ir;
      setOperands(a, b);
      @(negedge CLK);
      checkOutput({tag, "/fetch"}, 32'(obs), 32'(fetchOuts()));
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput({tag, "/exec"}, 32'(obs), 32'(refExec(ir, a, b)));
`ifdef OTTER_CTRL_INTR_EN
      checkOutput({tag, "/mret"}, 32'(MRET_EXEC),
                  32'(ir[6:0] == 7'b1110011 && ir[14:12] == 3'b000 && ir[31:20] == 12'h302));
`endif
      @(posedge CLK); #1;
      if (ir[6:0] == 7'b0000011) begin
         @(negedge CLK);
         checkOutput({tag, "/wb"}, 32'(obs), 32'(wbOuts()));
         @(posedge CLK); #1;
      end
   endtask

   // Random instruction: mostly legal opcodes, occasionally an illegal one
   function automatic logic [31:0] randomInstr();
      logic [6:0]  legal [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                  7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1110011};
      logic [31:0] upper = $urandom();
      logic [6:0]  opc;
      int          pick = $urandom_range(0, 10);
      if (pick < 10) begin
         opc = legal[pick];
      end else begin
         opc = 7'($urandom());
         while (opc inside {legal}) opc = 7'($urandom());
      end
      return {upper[31:7], opc};
   endfunction

   initial begin
      logic [31:0] a, b, ir;

      RST = 1'b1; IR = 32'h0; BR_EQ = 0; BR_LT = 0; BR_LTU = 0;
`ifdef OTTER_CTRL_INTR_EN
      INTR = 1'b0; CSR_MIE = 1'b0;
`endif
      #1;
      @(negedge CLK);
      checkOutput("reset0", 32'(obs), 32'h0);
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("reset1", 32'(obs), 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("init", 32'(obs), 32'h0);
      @(posedge CLK); #1;

      // Directed instructions
      applyStimulus("add", 32'h002081B3, 32'd1, 32'd2);
      applyStimulus("sub", 32'h402081B3, 32'd1, 32'd2);
      applyStimulus("srai", 32'h4030D093, 32'd0, 32'd0);
      applyStimulus("xori", 32'h4030C093, 32'd0, 32'd0);
      applyStimulus("lui", 32'h123452B7, 32'd0, 32'd0);
      applyStimulus("lw", 32'h00012083, 32'd0, 32'd0);
      applyStimulus("bne_taken", 32'h00209463, 32'd5, 32'd7);
      applyStimulus("bne_not", 32'h00209463, 32'd9, 32'd9);
      applyStimulus("sys_nop", 32'h00000073, 32'd0, 32'd0);

      // Spot-check ALU codes against literal values, independently of the model
      IR = 32'h402081B3; @(negedge CLK); @(posedge CLK); #1; @(negedge CLK);
      checkOutput("sub_fun", 32'(ALU_FUN), 32'h8);
      @(posedge CLK); #1;
      IR = 32'h4030D093; @(negedge CLK); @(posedge CLK); #1; @(negedge CLK);
      checkOutput("srai_fun", 32'(ALU_FUN), 32'hD);
      @(posedge CLK); #1;

      // Reset in the middle of a load's WB cycle
      IR = 32'h00012083;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("rst_wb_rfwe", 32'(RF_WE), 32'h0);
      checkOutput("rst_wb_all", 32'(obs), 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("rst_wb_init", 32'(obs), 32'h0);
      @(posedge CLK); #1;

`ifdef OTTER_CTRL_INTR_EN
      // Interrupt taken at the end of an add
      IR = 32'h002081B3;
      @(negedge CLK);
      checkOutput("intr/fetch", 32'(obs), 32'(fetchOuts()));
      @(posedge CLK); #1;
      INTR = 1'b1; CSR_MIE = 1'b1;
      @(negedge CLK);
      checkOutput("intr/exec", 32'(obs), 32'(refExec(IR, 0, 0)));
      @(posedge CLK); #1;
      INTR = 1'b0; CSR_MIE = 1'b0;
      @(negedge CLK);
      checkOutput("intr/pcsrc", 32'(PC_SOURCE), 32'd4);
      checkOutput("intr/pcwe", 32'(PC_WE), 32'd1);
      checkOutput("intr/taken", 32'(INT_TAKEN), 32'd1);
      @(posedge CLK); #1;
`endif

      // Random instruction stream with related and unrelated operands
      for (int i = 0; i < 60; i++) begin
         ir = randomInstr();
         a  = $urandom();
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = ~a;
            default: b = $urandom();
         endcase
         applyStimulus("rand", ir, a, b);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
